// File: rtl/mul_res_fifo.sv
`default_nettype none
// ============================================================================
// mul_res_fifo : FWFT result FIFO behind the 3-bit sign-magnitude multiplier
// Rev 1.0 - initial release
// ============================================================================
module mul_res_fifo #(
  parameter int RES_W = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [RES_W-1:0] i_res,
  output logic             o_in_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [RES_W-1:0] o_res,
  output logic             o_sf,
  output logic             o_zf,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RES_W-1:0] mem_res [DEPTH];
  logic [DEPTH-1:0] mem_zf;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;
  logic             wr_zero;
  logic [RES_W-1:0] wr_data;

  // Full/empty come from the occupancy count so equal pointers stay unambiguous.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = i_valid & ~full;
  assign rd_en   = i_ready & ~empty;

  // Negative zero is folded to +0 before it ever reaches storage.
  assign wr_zero = (i_res[RES_W-2:0] == '0);
  assign wr_data = wr_zero ? '0 : i_res;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_en && !rd_en) begin
        count <= count + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
        count <= count - CNT_W'(1);
      end
      if (i_valid && full) begin
        ovf <= 1'b1;
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_clr) begin
      mem_res[wr_ptr] <= wr_data;
      mem_zf[wr_ptr]  <= wr_zero;
    end
  end

  assign o_in_ready = ~full;
  assign o_valid    = ~empty;
  assign o_res      = empty ? '0 : mem_res[rd_ptr];
  assign o_sf       = ~empty & mem_res[rd_ptr][RES_W-1];
  assign o_zf       = ~empty & mem_zf[rd_ptr];
  assign o_count    = count;
  assign o_ovf      = ovf;

endmodule
`default_nettype wire
